// File: rtl/sram_lsu_adapter_if.sv
// ---------------------------------------------------------------------------
// sram_lsu_adapter_if
// Bundles the signals between the CPU, the load/store adapter and the
// scratchpad SRAM controller.
//   CPU request : req_valid, req_ready, req_we, req_size, req_signed,
//                 req_addr, req_wdata
//   CPU response: rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   SRAM port   : sram_req, sram_we, sram_be, sram_addr, sram_wdata,
//                 sram_rdata
//   Status      : pd_en, ret_en, mbist_en (inputs), err_count (output)
// modport slave  : adapter side
// modport master : CPU/SRAM/environment side
// ---------------------------------------------------------------------------
interface sram_lsu_adapter_if #(
  parameter int ADDR_W   = 32,
  parameter int SRAM_AW  = 13,
  parameter int ERRCNT_W = 8
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [ADDR_W-1:0]   req_addr;
  logic [31:0]         req_wdata;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_rdata;
  logic [1:0]          rsp_err;

  logic                sram_req;
  logic                sram_we;
  logic [3:0]          sram_be;
  logic [SRAM_AW-1:0]  sram_addr;
  logic [31:0]         sram_wdata;
  logic [31:0]         sram_rdata;

  logic                pd_en;
  logic                ret_en;
  logic                mbist_en;
  logic [ERRCNT_W-1:0] err_count;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output sram_req, sram_we, sram_be, sram_addr, sram_wdata,
    input  sram_rdata,
    input  pd_en, ret_en, mbist_en,
    output err_count
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  sram_req, sram_we, sram_be, sram_addr, sram_wdata,
    output sram_rdata,
    output pd_en, ret_en, mbist_en,
    input  err_count
  );
endinterface

// File: rtl/sram_lsu_adapter.sv
// ---------------------------------------------------------------------------
// sram_lsu_adapter
// Load/store front-end for the 8 KB scratchpad SRAM. Accepts one CPU
// byte/half/word access at a time, classifies it (unavailable / out of range /
// misaligned), issues a single-cycle SRAM request with byte enables and
// lane-replicated write data, aligns and extends load data, and returns the
// result with an error code on a valid/ready response channel.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : sram_lsu_adapter_if.slave (CPU request/response, SRAM port,
//           power/MBIST status, saturating error counter)
// ---------------------------------------------------------------------------
module sram_lsu_adapter #(
  parameter int ADDR_W   = 32,
  parameter int SRAM_AW  = 13,
  parameter int ERRCNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_lsu_adapter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_UNAVAIL = 2'b11;

  state_t              state_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [1:0]          addr_q;       // only the lane offset is needed after issue
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic [1:0]          rsp_err_q;
  logic                sram_req_q;
  logic                sram_we_q;
  logic [3:0]          sram_be_q;
  logic [SRAM_AW-1:0]  sram_addr_q;
  logic [31:0]         sram_wdata_q;
  logic [ERRCNT_W-1:0] err_count_q;

  logic                unavail;
  logic                out_of_range;
  logic                misaligned;
  logic [1:0]          req_code_d;
  logic [3:0]          be_d;
  logic [31:0]         wdata_d;
  logic [7:0]          lane_byte;
  logic [15:0]         lane_half;
  logic [31:0]         load_d;
  logic [ERRCNT_W-1:0] err_count_d;

  assign unavail      = ~bus.pd_en | bus.ret_en | bus.mbist_en;
  assign out_of_range = |bus.req_addr[ADDR_W-1:SRAM_AW];
  assign misaligned   = (bus.req_size == 2'b11) ||
                        (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                        (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

  // Classification of the incoming request, highest priority first.
  always_comb begin
    req_code_d = ERR_OK;
    if (unavail)           req_code_d = ERR_UNAVAIL;
    else if (out_of_range) req_code_d = ERR_RANGE;
    else if (misaligned)   req_code_d = ERR_ALIGN;
  end

  // Byte enables and replicated write data, computed from the live request so
  // the SRAM port is already driven during the ISSUE cycle.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be_d    = 4'b0001 << bus.req_addr[1:0];
        wdata_d = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {bus.req_addr[1], 1'b0};
        wdata_d = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection and sign/zero extension of the registered SRAM read data.
  always_comb begin
    lane_byte = bus.sram_rdata[7:0];
    case (addr_q)
      2'b01:   lane_byte = bus.sram_rdata[15:8];
      2'b10:   lane_byte = bus.sram_rdata[23:16];
      2'b11:   lane_byte = bus.sram_rdata[31:24];
      default: ;
    endcase
    lane_half = addr_q[1] ? bus.sram_rdata[31:16] : bus.sram_rdata[15:0];
    case (size_q)
      2'b00:   load_d = {{24{signed_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_d = {{16{signed_q & lane_half[15]}}, lane_half};
      default: load_d = bus.sram_rdata;
    endcase
  end

  assign err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= 2'b00;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= ERR_OK;
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_be_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      err_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            size_q      <= bus.req_size;
            signed_q    <= bus.req_signed;
            addr_q      <= bus.req_addr[1:0];
            req_ready_q <= 1'b0;
            if (req_code_d != ERR_OK) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= req_code_d;
              rsp_rdata_q <= '0;
              err_count_q <= err_count_d;
            end else begin
              state_q      <= ISSUE;
              sram_req_q   <= 1'b1;
              sram_we_q    <= bus.req_we;
              sram_be_q    <= be_d;
              sram_addr_q  <= {bus.req_addr[SRAM_AW-1:2], 2'b00};
              sram_wdata_q <= wdata_d;
            end
          end
        end
        ISSUE: begin
          sram_req_q   <= 1'b0;
          sram_we_q    <= 1'b0;
          sram_be_q    <= '0;
          sram_addr_q  <= '0;
          sram_wdata_q <= '0;
          if (unavail) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_UNAVAIL;
            rsp_rdata_q <= '0;
            err_count_q <= err_count_d;
          end else if (we_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_OK;
            rsp_rdata_q <= '0;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          if (unavail) begin
            rsp_err_q   <= ERR_UNAVAIL;
            rsp_rdata_q <= '0;
            err_count_q <= err_count_d;
          end else begin
            rsp_err_q   <= ERR_OK;
            rsp_rdata_q <= load_d;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  // The request strobe is registered, but power loss during the ISSUE cycle
  // must still keep the SRAM from being accessed, so it is qualified here.
  assign bus.sram_req   = sram_req_q & ~unavail;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_be    = sram_be_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_sram_lsu_adapter.sv
// ---------------------------------------------------------------------------
// tb_sram_lsu_adapter
// Drives directed and random CPU accesses into sram_lsu_adapter, models the
// SRAM behind it, and compares every response against a byte-array reference
// model of the scratchpad.
// ---------------------------------------------------------------------------
module tb_sram_lsu_adapter;

  localparam int ADDR_W   = 32;
  localparam int SRAM_AW  = 13;
  localparam int ERRCNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_clear;

  always #5 clk = ~clk;

  sram_lsu_adapter_if #(.ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW), .ERRCNT_W(ERRCNT_W)) bus ();

  sram_lsu_adapter #(.ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW), .ERRCNT_W(ERRCNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // SRAM controller model: write by byte enables, read data registered.
  logic [31:0] sram_mem [0:2047];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int w = 0; w < 2048; w++) sram_mem[w] <= 32'h0;
      bus.sram_rdata <= 32'h0;
    end else if (bus.sram_req) begin
      if (bus.sram_we) begin
        for (int k = 0; k < 4; k++)
          if (bus.sram_be[k]) sram_mem[bus.sram_addr[12:2]][8*k +: 8] <= bus.sram_wdata[8*k +: 8];
      end else begin
        bus.sram_rdata <= sram_mem[bus.sram_addr[12:2]];
      end
    end
  end

  // Reference scratchpad, one byte per entry.
  logic [7:0] ref_mem [0:8191];

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int exp_errcnt = 0;
  int txn_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected behaviour computed from the access rules with plain arithmetic.
  function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic pd, input logic ret, input logic mb,
                                output logic [1:0] code, output logic [31:0] rdata,
                                output logic [3:0] be, output logic [31:0] wd);
    int nbytes;
    int off;
    logic [31:0] v;
    nbytes = 1 << size;
    off    = int'(addr % 4);
    if (!pd || ret || mb)                                      code = 2'd3;
    else if (addr >= 32'd8192)                                 code = 2'd2;
    else if (size == 2'd3 || (addr % nbytes) != 0)             code = 2'd1;
    else                                                       code = 2'd0;
    be = 4'b0000;
    wd = 32'h0;
    rdata = 32'h0;
    if (code == 2'd0) begin
      for (int i = 0; i < nbytes; i++) be[off + i] = 1'b1;
      for (int k = 0; k < 4; k++) wd[8*k +: 8] = wdata[8*(k % nbytes) +: 8];
      if (!we) begin
        v = 32'h0;
        for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8*i));
        if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
        rdata = v;
      end
    end
  endfunction

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic pd, input logic ret, input logic mb, input int stall);
    logic [1:0]  code;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wd;
    int lat, n_sram, exp_lat;
    logic [3:0]  got_be;
    logic [31:0] got_addr, got_wdata;
    logic        got_we;
    model(we, size, sgn, addr, wdata, pd, ret, mb, code, rdata, be, wd);
    exp_lat = (code != 2'd0) ? 1 : (we ? 2 : 3);
    got_be = 4'h0; got_addr = 32'h0; got_wdata = 32'h0; got_we = 1'b0;

    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata;
    bus.pd_en = pd; bus.ret_en = ret; bus.mbist_en = mb; bus.rsp_ready = 1'b0;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    lat = 0; n_sram = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.req_valid = 1'b0;
      if (bus.sram_req) begin
        n_sram++;
        got_be = bus.sram_be; got_addr = 32'(bus.sram_addr);
        got_wdata = bus.sram_wdata; got_we = bus.sram_we;
      end
    end while (!bus.rsp_valid && lat < 6);

    if (code != 2'd0) exp_errcnt = (exp_errcnt < 255) ? exp_errcnt + 1 : 255;
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("rsp_err", 32'(bus.rsp_err), 32'(code));
    chk("rsp_rdata", bus.rsp_rdata, rdata);
    chk("err_count", 32'(bus.err_count), 32'(exp_errcnt));
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    chk("sram_req_count", 32'(n_sram), (code == 2'd0) ? 32'd1 : 32'd0);
    chk("sram_idle_in_resp", 32'(bus.sram_req), 32'd0);
    if (n_sram != 0) begin
      chk("sram_be", 32'(got_be), 32'(be));
      chk("sram_addr", got_addr, addr & 32'h0000_1FFC);
      chk("sram_we", 32'(got_we), 32'(we));
      if (we) chk("sram_wdata", got_wdata, wd);
    end

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rsp_rdata", bus.rsp_rdata, rdata);
      chk("stall_rsp_err", 32'(bus.rsp_err), 32'(code));
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    chk("req_ready_back", 32'(bus.req_ready), 32'd1);

    if (code == 2'd0 && we)
      for (int i = 0; i < (1 << size); i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
    txn_no++;
    $display("txn %0d: we=%0d size=%0d sgn=%0d addr=0x%08h wdata=0x%08h err=%0d rdata=0x%08h lat=%0d",
             txn_no, we, size, sgn, addr, wdata, bus.rsp_err, rdata, lat);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"},  32'(bus.req_ready), 32'd1);
    chk({pfx, "_rsp_valid"},  32'(bus.rsp_valid), 32'd0);
    chk({pfx, "_rsp_rdata"},  bus.rsp_rdata, 32'd0);
    chk({pfx, "_rsp_err"},    32'(bus.rsp_err), 32'd0);
    chk({pfx, "_sram_req"},   32'(bus.sram_req), 32'd0);
    chk({pfx, "_sram_we"},    32'(bus.sram_we), 32'd0);
    chk({pfx, "_sram_be"},    32'(bus.sram_be), 32'd0);
    chk({pfx, "_sram_addr"},  32'(bus.sram_addr), 32'd0);
    chk({pfx, "_sram_wdata"}, bus.sram_wdata, 32'd0);
    chk({pfx, "_err_count"},  32'(bus.err_count), 32'd0);
  endtask

  initial begin
    logic        r_we, r_sgn, r_pd, r_ret, r_mb;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;
    int          sel;

    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0; mem_clear = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
    bus.pd_en = 1'b1; bus.ret_en = 1'b0; bus.mbist_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    mem_clear = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed accesses from the test plan.
    do_req(1'b1, 2'b10, 1'b0, 32'h0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0010, 32'h0,         1'b1, 1'b0, 1'b0, 0);
    do_req(1'b1, 2'b00, 1'b0, 32'h0013, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 0);
    do_req(1'b0, 2'b00, 1'b1, 32'h0013, 32'h0,         1'b1, 1'b0, 1'b0, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'h0013, 32'h0,         1'b1, 1'b0, 1'b0, 0);
    do_req(1'b1, 2'b01, 1'b0, 32'h0022, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h0022, 32'h0,         1'b1, 1'b0, 1'b0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h0021, 32'h0,         1'b1, 1'b0, 1'b0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0,         1'b1, 1'b0, 1'b0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0010, 32'h0,         1'b1, 1'b1, 1'b0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0010, 32'h0,         1'b1, 1'b0, 1'b1, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h0010, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h0010, 32'h0,         1'b1, 1'b0, 1'b0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0010, 32'h0,         1'b1, 1'b0, 1'b0, 5);

    // Random accesses in a small window so loads see earlier stores.
    for (int n = 0; n < 150; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_sgn   = 1'($urandom_range(0, 1));
      sel     = int'($urandom_range(0, 15));
      r_addr  = (sel == 0) ? $urandom : 32'($urandom_range(0, 63));
      if (sel < 13 && r_size != 2'b11) r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      r_wdata = $urandom;
      r_pd    = ($urandom_range(0, 15) != 0);
      r_ret   = ($urandom_range(0, 15) == 0);
      r_mb    = ($urandom_range(0, 15) == 0);
      do_req(r_we, r_size, r_sgn, r_addr, r_wdata, r_pd, r_ret, r_mb, int'($urandom_range(0, 2)));
    end

    // Error counter saturation.
    for (int n = 0; n < 260; n++)
      do_req(1'($urandom_range(0, 1)), 2'b10, 1'b0, 32'(4 * $urandom_range(0, 15) + 1),
             $urandom, 1'b1, 1'b0, 1'b0, 0);
    chk("err_count_saturated", 32'(bus.err_count), 32'h0000_00FF);

    // Reset asserted while a load is in ISSUE.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0010; bus.pd_en = 1'b1; bus.ret_en = 1'b0; bus.mbist_en = 1'b0;
    @(posedge clk);
    #1;
    chk("issue_before_reset", 32'(bus.sram_req), 32'd1);
    rst_n = 1'b0;
    #1;
    bus.req_valid = 1'b0;
    chk_reset_outputs("midreset");
    exp_errcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_sram_after_reset", 32'(bus.sram_req), 32'd0);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h0010, 32'h0, 1'b1, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
